// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard scoreboard.
//   - stage_rec_t : per-stage destination record (valid, we, addr, tnew)
//   - FWD_GRF     : forward-select code meaning "take the register file"
//   - MUL_LAT_DEF / DIV_LAT_DEF : default multiply/divide busy latencies
//   - tnew_dec()  : saturating Tnew countdown used as records advance
// The tnew field is TNEW_W wide so that any configured TW <= TNEW_W fits
// zero-extended without changing the record type.
package hazard_pkg;

  localparam int TNEW_W      = 8;
  localparam int FWD_GRF     = 0;
  localparam int MUL_LAT_DEF = 5;
  localparam int DIV_LAT_DEF = 10;

  typedef struct packed {
    logic              valid;
    logic              we;
    logic [4:0]        addr;
    logic [TNEW_W-1:0] tnew;
  } stage_rec_t;

  function automatic logic [TNEW_W-1:0] tnew_dec(input logic [TNEW_W-1:0] t);
    return (t == '0) ? '0 : t - TNEW_W'(1);
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode-side bundle between the decode stage (master) and the hazard
// scoreboard (slave).
//   master drives : rs/rt addresses, use bits, Tuse, destination, Tnew,
//                   mult/div controls, flush
//   slave drives  : stall, decode/E forward selects, md_busy, stall_cnt
interface hazard_scoreboard_if #(
  parameter int TW = 2,
  parameter int SW = 2
);

  logic [4:0]    rs_addr;
  logic [4:0]    rt_addr;
  logic          use_rs;
  logic          use_rt;
  logic [TW-1:0] tuse_rs;
  logic [TW-1:0] tuse_rt;
  logic [4:0]    dst_addr;
  logic          dst_we;
  logic [TW-1:0] tnew_d;
  logic          md_start;
  logic          md_is_div;
  logic          md_use;
  logic          flush;

  logic          stall;
  logic [SW-1:0] fwd_d_rs;
  logic [SW-1:0] fwd_d_rt;
  logic [SW-1:0] fwd_e_rs;
  logic [SW-1:0] fwd_e_rt;
  logic          md_busy;
  logic [31:0]   stall_cnt;

  modport master (
    output rs_addr, rt_addr, use_rs, use_rt, tuse_rs, tuse_rt,
           dst_addr, dst_we, tnew_d, md_start, md_is_div, md_use, flush,
    input  stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, md_busy, stall_cnt
  );

  modport slave (
    input  rs_addr, rt_addr, use_rs, use_rt, tuse_rs, tuse_rt,
           dst_addr, dst_we, tnew_d, md_start, md_is_div, md_use, flush,
    output stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, md_busy, stall_cnt
  );

endinterface

// File: rtl/hazard_md_timer.sv
// Multiply/divide busy timer.
//   clk, reset : clock, synchronous active-high reset (clears the counter)
//   load_i     : mult/div entering stage 1 this cycle
//   is_div_i   : load DIV_LAT instead of MUL_LAT
//   busy_o     : counter non-zero
module hazard_md_timer
  import hazard_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  input  logic is_div_i,
  output logic busy_o
);

  localparam int MAX_LAT = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = is_div_i ? CW'(DIV_LAT) : CW'(MUL_LAT);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Depth-generic hazard unit for the in-order MIPS pipeline.
// Keeps one destination record per post-decode stage (1 = E .. NSTAGE = W),
// counting Tnew down as records advance, and derives the decode stall,
// decode forward selects and E-stage forward selects from them.
//   clk, reset : clock, synchronous active-high reset
//   hz (slave) : decode operands/destination/mult-div controls in;
//                stall, fwd_d_rs/rt, fwd_e_rs/rt, md_busy, stall_cnt out
// Optional: define HAZ_STATS_EN to build the saturating stall counter;
// otherwise stall_cnt is tied to zero.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NSTAGE  = 3,
  parameter int TW      = 2,
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF,
  parameter int SW      = 2
) (
  input  logic          clk,
  input  logic          reset,
  hazard_scoreboard_if.slave hz
);

  stage_rec_t rec_q [1:NSTAGE];
  stage_rec_t rec_d [1:NSTAGE];

  // Operand info kept only for stage 1, feeding the E-stage forward selects.
  logic [4:0] e1_rs_q, e1_rs_d;
  logic [4:0] e1_rt_q, e1_rt_d;
  logic       e1_use_rs_q, e1_use_rs_d;
  logic       e1_use_rt_q, e1_use_rt_d;

  logic          stall_data;
  logic          stall_md;
  logic          stall;
  logic          md_busy;
  logic          md_load;
  logic [SW-1:0] fwd_d_rs, fwd_d_rt;
  logic [SW-1:0] fwd_e_rs, fwd_e_rt;

  function automatic logic rec_match(input stage_rec_t r, input logic [4:0] a);
    return r.valid && r.we && (r.addr == a) && (a != 5'd0);
  endfunction

  // Decode point: scanning from the oldest stage toward stage 1 leaves the
  // nearest (youngest) producer in hit/t/k. Only that producer matters: if
  // it is not ready yet, an older ready copy of the register is stale.
  always_comb begin : decode_hazard
    logic              hit_rs, hit_rt;
    logic [TNEW_W-1:0] t_rs, t_rt;
    int                k_rs, k_rt;
    hit_rs = 1'b0;
    hit_rt = 1'b0;
    t_rs   = '0;
    t_rt   = '0;
    k_rs   = 0;
    k_rt   = 0;
    for (int k = NSTAGE; k >= 1; k--) begin
      if (rec_match(rec_q[k], hz.rs_addr)) begin
        hit_rs = 1'b1;
        t_rs   = rec_q[k].tnew;
        k_rs   = k;
      end
      if (rec_match(rec_q[k], hz.rt_addr)) begin
        hit_rt = 1'b1;
        t_rt   = rec_q[k].tnew;
        k_rt   = k;
      end
    end
    stall_data = (hz.use_rs && hit_rs && (t_rs > TNEW_W'(hz.tuse_rs))) ||
                 (hz.use_rt && hit_rt && (t_rt > TNEW_W'(hz.tuse_rt)));
    fwd_d_rs = (hit_rs && (t_rs == '0)) ? SW'(k_rs) : SW'(FWD_GRF);
    fwd_d_rt = (hit_rt && (t_rt == '0)) ? SW'(k_rt) : SW'(FWD_GRF);
  end

  // E stage: the same nearest-producer rule, searched over stages 2..NSTAGE.
  always_comb begin : e_forward
    logic              hit_rs, hit_rt;
    logic [TNEW_W-1:0] t_rs, t_rt;
    int                k_rs, k_rt;
    hit_rs = 1'b0;
    hit_rt = 1'b0;
    t_rs   = '0;
    t_rt   = '0;
    k_rs   = 0;
    k_rt   = 0;
    for (int k = NSTAGE; k >= 2; k--) begin
      if (rec_match(rec_q[k], e1_rs_q)) begin
        hit_rs = 1'b1;
        t_rs   = rec_q[k].tnew;
        k_rs   = k;
      end
      if (rec_match(rec_q[k], e1_rt_q)) begin
        hit_rt = 1'b1;
        t_rt   = rec_q[k].tnew;
        k_rt   = k;
      end
    end
    fwd_e_rs = (e1_use_rs_q && hit_rs && (t_rs == '0)) ? SW'(k_rs) : SW'(FWD_GRF);
    fwd_e_rt = (e1_use_rt_q && hit_rt && (t_rt == '0)) ? SW'(k_rt) : SW'(FWD_GRF);
  end

  assign stall_md = hz.md_use && md_busy;
  assign stall    = stall_data || stall_md;
  assign md_load  = hz.md_start && !stall && !hz.flush;

  always_comb begin : next_records
    for (int k = 1; k <= NSTAGE; k++) begin
      rec_d[k] = '0;
    end
    e1_rs_d     = '0;
    e1_rt_d     = '0;
    e1_use_rs_d = 1'b0;
    e1_use_rt_d = 1'b0;
    // Flush and stall both bubble stage 1; downstream stages never stall.
    if (!(stall || hz.flush)) begin
      rec_d[1].valid = 1'b1;
      rec_d[1].we    = hz.dst_we;
      rec_d[1].addr  = hz.dst_addr;
      rec_d[1].tnew  = TNEW_W'(hz.tnew_d);
      e1_rs_d        = hz.rs_addr;
      e1_rt_d        = hz.rt_addr;
      e1_use_rs_d    = hz.use_rs;
      e1_use_rt_d    = hz.use_rt;
    end
    for (int k = 2; k <= NSTAGE; k++) begin
      rec_d[k]      = rec_q[k-1];
      rec_d[k].tnew = tnew_dec(rec_q[k-1].tnew);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 1; k <= NSTAGE; k++) begin
        rec_q[k] <= '0;
      end
      e1_rs_q     <= '0;
      e1_rt_q     <= '0;
      e1_use_rs_q <= 1'b0;
      e1_use_rt_q <= 1'b0;
    end else begin
      for (int k = 1; k <= NSTAGE; k++) begin
        rec_q[k] <= rec_d[k];
      end
      e1_rs_q     <= e1_rs_d;
      e1_rt_q     <= e1_rt_d;
      e1_use_rs_q <= e1_use_rs_d;
      e1_use_rt_q <= e1_use_rt_d;
    end
  end

  hazard_md_timer #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT)
  ) u_md_timer (
    .clk      (clk),
    .reset    (reset),
    .load_i   (md_load),
    .is_div_i (hz.md_is_div),
    .busy_o   (md_busy)
  );

`ifdef HAZ_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign hz.stall_cnt = stall_cnt_q;
`else
  assign hz.stall_cnt = '0;
`endif

  assign hz.stall    = stall;
  assign hz.fwd_d_rs = fwd_d_rs;
  assign hz.fwd_d_rt = fwd_d_rt;
  assign hz.fwd_e_rs = fwd_e_rs;
  assign hz.fwd_e_rt = fwd_e_rt;
  assign hz.md_busy  = md_busy;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: load-use, branch, jal/jr, multiple
// producers, $0, div/mfhi busy window, flush and reset-while-busy.
module tb_hazard_scoreboard;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

`ifdef HAZ_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  hazard_scoreboard_if #(.TW(2), .SW(2)) hz_if ();

  hazard_scoreboard #(
    .NSTAGE (3),
    .TW     (2),
    .MUL_LAT(5),
    .DIV_LAT(10),
    .SW     (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are checked
  // 1 unit later, well before the next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    hz_if.rs_addr   = '0;
    hz_if.rt_addr   = '0;
    hz_if.use_rs    = 1'b0;
    hz_if.use_rt    = 1'b0;
    hz_if.tuse_rs   = '0;
    hz_if.tuse_rt   = '0;
    hz_if.dst_addr  = '0;
    hz_if.dst_we    = 1'b0;
    hz_if.tnew_d    = '0;
    hz_if.md_start  = 1'b0;
    hz_if.md_is_div = 1'b0;
    hz_if.md_use    = 1'b0;
    hz_if.flush     = 1'b0;
  endtask

  task automatic prod(input logic [4:0] dst, input logic [1:0] tnew);
    idle();
    hz_if.dst_addr = dst;
    hz_if.dst_we   = 1'b1;
    hz_if.tnew_d   = tnew;
  endtask

  task automatic cons(input logic [4:0] rs, input logic [1:0] trs,
                      input logic [4:0] rt, input logic [1:0] trt);
    idle();
    hz_if.rs_addr = rs;
    hz_if.use_rs  = 1'b1;
    hz_if.tuse_rs = trs;
    hz_if.rt_addr = rt;
    hz_if.use_rt  = 1'b1;
    hz_if.tuse_rt = trt;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    idle();
    step();
    step();
    settle();
    chk("rst_stall", 32'(hz_if.stall), 32'd0);
    chk("rst_fwd_d_rs", 32'(hz_if.fwd_d_rs), 32'd0);
    chk("rst_fwd_e_rs", 32'(hz_if.fwd_e_rs), 32'd0);
    chk("rst_md_busy", 32'(hz_if.md_busy), 32'd0);
    chk("rst_stall_cnt", hz_if.stall_cnt, 32'd0);
    reset = 1'b0;

    // lw $2 (tnew 2) then add $3,$2,$4 (tuse 1)
    step(); prod(5'd2, 2'd2); settle();
    chk("lw_stall", 32'(hz_if.stall), 32'd0);
    step(); cons(5'd2, 2'd1, 5'd4, 2'd1);
    hz_if.dst_addr = 5'd3; hz_if.dst_we = 1'b1; hz_if.tnew_d = 2'd1; settle();
    chk("lu_stall", 32'(hz_if.stall), 32'd1);
    chk("lu_fwd_d_rs", 32'(hz_if.fwd_d_rs), 32'd0);
    step(); settle();
    chk("lu_stall2", 32'(hz_if.stall), 32'd0);
    chk("lu_fwd_d_rs2", 32'(hz_if.fwd_d_rs), 32'd0);
    step(); idle(); settle();
    chk("lu_fwd_e_rs", 32'(hz_if.fwd_e_rs), 32'd3);
    chk("lu_fwd_e_rt", 32'(hz_if.fwd_e_rt), 32'd0);

    // addu $5 (tnew 1) then beq $5,$0 (tuse 0)
    step(); prod(5'd5, 2'd1); settle();
    chk("addu_stall", 32'(hz_if.stall), 32'd0);
    step(); cons(5'd5, 2'd0, 5'd0, 2'd0); settle();
    chk("beq_stall", 32'(hz_if.stall), 32'd1);
    step(); settle();
    chk("beq_stall2", 32'(hz_if.stall), 32'd0);
    chk("beq_fwd_d_rs", 32'(hz_if.fwd_d_rs), 32'd2);
    chk("beq_fwd_d_rt0", 32'(hz_if.fwd_d_rt), 32'd0);

    // jal (dst 31, tnew 0) then jr $31
    step(); prod(5'd31, 2'd0); settle();
    chk("jal_stall", 32'(hz_if.stall), 32'd0);
    chk("beq_fwd_e_rs", 32'(hz_if.fwd_e_rs), 32'd3);
    step(); cons(5'd31, 2'd0, 5'd0, 2'd0); hz_if.use_rt = 1'b0; settle();
    chk("jr_stall", 32'(hz_if.stall), 32'd0);
    chk("jr_fwd_d_rs", 32'(hz_if.fwd_d_rs), 32'd1);

    // two producers of $6, then a reader; then a write to $0 and a reader
    step(); prod(5'd6, 2'd0); settle();
    step(); prod(5'd6, 2'd0); settle();
    step(); cons(5'd6, 2'd0, 5'd6, 2'd0); settle();
    chk("dup_stall", 32'(hz_if.stall), 32'd0);
    chk("dup_fwd_d_rs", 32'(hz_if.fwd_d_rs), 32'd1);
    chk("dup_fwd_d_rt", 32'(hz_if.fwd_d_rt), 32'd1);
    step(); prod(5'd0, 2'd2); settle();
    step(); cons(5'd0, 2'd0, 5'd0, 2'd0); settle();
    chk("r0_stall", 32'(hz_if.stall), 32'd0);
    chk("r0_fwd_d_rs", 32'(hz_if.fwd_d_rs), 32'd0);

    // div then mfhi: ten stall cycles
    step(); idle(); hz_if.md_start = 1'b1; hz_if.md_is_div = 1'b1; hz_if.md_use = 1'b1; settle();
    chk("div_stall", 32'(hz_if.stall), 32'd0);
    chk("div_busy0", 32'(hz_if.md_busy), 32'd0);
    step(); prod(5'd8, 2'd1); hz_if.md_use = 1'b1; settle();
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("mfhi_busy%0d", i), 32'(hz_if.md_busy), 32'd1);
      chk($sformatf("mfhi_stall%0d", i), 32'(hz_if.stall), 32'd1);
      step(); settle();
    end
    chk("mfhi_go_stall", 32'(hz_if.stall), 32'd0);
    chk("mfhi_go_busy", 32'(hz_if.md_busy), 32'd0);
    chk("stats_12", hz_if.stall_cnt, STATS ? 32'd12 : 32'd0);

    // flushed mult+producer of $7: no forward, no timer load
    step(); prod(5'd7, 2'd0); hz_if.md_start = 1'b1; hz_if.flush = 1'b1; settle();
    chk("fl_stall", 32'(hz_if.stall), 32'd0);
    step(); cons(5'd7, 2'd0, 5'd0, 2'd0); settle();
    chk("fl_fwd_d_rs", 32'(hz_if.fwd_d_rs), 32'd0);
    chk("fl_md_busy", 32'(hz_if.md_busy), 32'd0);
    chk("fl_stall2", 32'(hz_if.stall), 32'd0);

    // mult, then mfhi stalled with flush asserted, then reset mid-busy
    step(); idle(); hz_if.md_start = 1'b1; hz_if.md_use = 1'b1; settle();
    chk("mult_stall", 32'(hz_if.stall), 32'd0);
    step(); prod(5'd9, 2'd1); hz_if.md_use = 1'b1; hz_if.flush = 1'b1; settle();
    chk("flst_stall", 32'(hz_if.stall), 32'd1);
    chk("flst_busy", 32'(hz_if.md_busy), 32'd1);
    step(); hz_if.flush = 1'b0; settle();
    chk("mult_stall2", 32'(hz_if.stall), 32'd1);
    chk("stats_13", hz_if.stall_cnt, STATS ? 32'd13 : 32'd0);
    reset = 1'b1;
    step(); reset = 1'b0; idle(); settle();
    chk("rst2_busy", 32'(hz_if.md_busy), 32'd0);
    chk("rst2_stall", 32'(hz_if.stall), 32'd0);
    chk("rst2_stall_cnt", hz_if.stall_cnt, 32'd0);
    chk("rst2_fwd_e_rs", 32'(hz_if.fwd_e_rs), 32'd0);
    hz_if.md_use = 1'b1; settle();
    chk("rst2_md_use", 32'(hz_if.stall), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
